// File: rtl/spi_rx_slave.sv
// SPI mode-0 receive slave: oversamples the SPI pins in the clk domain,
// assembles MSB-first bytes and shifts a host status byte out on MISO.
module spi_rx_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned VALID_HOLD  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] tx_data,
    output logic       tx_load_ack,
    output logic [7:0] spi_rx_data,
    output logic       spi_rx_valid,
    output logic       frame_active,
    output logic       rx_abort,
    output logic [7:0] byte_cnt
);

    localparam int unsigned HOLD_W  = $clog2(VALID_HOLD + 1);
    localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic [FLUSH_W-1:0]     flush_cnt;
    logic                   sclk_s, cs_s, mosi_s, flushed;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [2:0]        bit_cnt, bit_cnt_n;
    logic [7:0]        byte_cnt_n;
    logic [7:0]        rx_shift, rx_shift_n;
    logic [7:0]        tx_shift, tx_shift_n;
    logic [7:0]        rx_data_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic              restart, restart_n;
    logic              valid_n, ack_n, abort_n, done;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    // The cs_n chain resets to 1, so WAIT_IDLE must not trust it until a real sample arrives
    assign flushed   = (flush_cnt == FLUSH_W'(SYNC_STAGES));

    // Pin synchronizers, edge-detect delay stage and post-reset flush counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            flush_cnt <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            if (!flushed) flush_cnt <= flush_cnt + FLUSH_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= WAIT_IDLE;
        else      state <= state_n;
    end

    // Next-state, shift datapath and valid-pulse shaping
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        byte_cnt_n = byte_cnt;
        rx_shift_n = rx_shift;
        tx_shift_n = tx_shift;
        rx_data_n  = spi_rx_data;
        ack_n      = 1'b0;
        abort_n    = 1'b0;
        done       = 1'b0;
        valid_n    = spi_rx_valid;
        hold_n     = hold_cnt;
        restart_n  = restart;

        case (state)
            WAIT_IDLE: begin
                if (flushed && cs_s) state_n = IDLE;
            end
            IDLE: begin
                if (cs_fall) begin
                    bit_cnt_n  = 3'd0;
                    byte_cnt_n = 8'd0;
                    tx_shift_n = tx_data;
                    ack_n      = 1'b1;
                    state_n    = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    abort_n   = (bit_cnt != 3'd0);
                    bit_cnt_n = 3'd0;
                    state_n   = IDLE;
                end else if (sclk_rise) begin
                    rx_shift_n = {rx_shift[6:0], mosi_s};
                    if (bit_cnt == 3'd7) begin
                        done      = 1'b1;
                        bit_cnt_n = 3'd0;
                        rx_data_n = {rx_shift[6:0], mosi_s};
                        if (byte_cnt != 8'hFF) byte_cnt_n = byte_cnt + 8'd1;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt != 3'd0) begin
                        tx_shift_n = {tx_shift[6:0], 1'b0};
                    end else begin
                        tx_shift_n = tx_data;
                        ack_n      = 1'b1;
                    end
                end
            end
            default: state_n = WAIT_IDLE;
        endcase

        // hold_cnt counts the high cycles still owed after the current one
        if (done) begin
            if (spi_rx_valid) begin
                valid_n   = 1'b0;
                restart_n = 1'b1;
            end else begin
                valid_n   = 1'b1;
                hold_n    = HOLD_W'(VALID_HOLD - 1);
                restart_n = 1'b0;
            end
        end else if (restart) begin
            valid_n   = 1'b1;
            hold_n    = HOLD_W'(VALID_HOLD - 1);
            restart_n = 1'b0;
        end else if (spi_rx_valid) begin
            if (hold_cnt == '0) valid_n = 1'b0;
            else                hold_n  = hold_cnt - HOLD_W'(1);
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt      <= 3'd0;
            byte_cnt     <= 8'd0;
            rx_shift     <= 8'd0;
            tx_shift     <= 8'd0;
            spi_rx_data  <= 8'd0;
            spi_rx_valid <= 1'b0;
            hold_cnt     <= '0;
            restart      <= 1'b0;
            tx_load_ack  <= 1'b0;
            rx_abort     <= 1'b0;
            spi_miso     <= 1'b0;
            spi_miso_oe  <= 1'b0;
            frame_active <= 1'b0;
        end else begin
            bit_cnt      <= bit_cnt_n;
            byte_cnt     <= byte_cnt_n;
            rx_shift     <= rx_shift_n;
            tx_shift     <= tx_shift_n;
            spi_rx_data  <= rx_data_n;
            spi_rx_valid <= valid_n;
            hold_cnt     <= hold_n;
            restart      <= restart_n;
            tx_load_ack  <= ack_n;
            rx_abort     <= abort_n;
            spi_miso     <= (state_n == SHIFT) ? tx_shift_n[7] : 1'b0;
            spi_miso_oe  <= (state_n == SHIFT);
            frame_active <= (state_n == SHIFT);
        end
    end

endmodule

// File: tb/tb_spi_rx_slave.sv
// Self-checking bench for spi_rx_slave: an SPI master model drives frames,
// a monitor records what the slave presents, and a byte-level model of the
// expected traffic is compared against it.
`timescale 1ns/1ps
module tb_spi_rx_slave;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned VALID_HOLD  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       spi_miso, spi_miso_oe, tx_load_ack, spi_rx_valid, frame_active, rx_abort;
    logic [7:0] spi_rx_data, byte_cnt;

    spi_rx_slave #(.SYNC_STAGES(SYNC_STAGES), .VALID_HOLD(VALID_HOLD)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .tx_data(tx_data), .tx_load_ack(tx_load_ack),
        .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
        .frame_active(frame_active), .rx_abort(rx_abort), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Single comparison point for the whole bench
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: what the slave actually presented
    logic [7:0] obs_rx[$];
    int         obs_w[$];
    int         ack_cnt = 0, abort_cnt = 0, oe_cnt = 0, unstable_cnt = 0;
    logic       v_prev = 1'b0;
    int         w = 0;
    logic [7:0] held = 8'h00;

    always @(negedge clk) begin
        if (tx_load_ack === 1'b1) ack_cnt++;
        if (rx_abort === 1'b1)    abort_cnt++;
        if (spi_miso_oe === 1'b1) oe_cnt++;
        if (spi_rx_valid === 1'b1 && !v_prev) begin
            obs_rx.push_back(spi_rx_data);
            held = spi_rx_data;
            w = 1;
        end else if (spi_rx_valid === 1'b1) begin
            w++;
            if (spi_rx_data !== held) unstable_cnt++;
        end else if (v_prev) begin
            obs_w.push_back(w);
        end
        v_prev = (spi_rx_valid === 1'b1);
    end

    // Master model and expected traffic
    int unsigned phase = 2;
    logic [7:0]  mbytes[5];
    logic [7:0]  miso_bytes[$];
    logic [7:0]  exp_rx[$];
    logic [7:0]  exp_miso[$];
    int          exp_ack = 0, exp_abort = 0;

    task automatic sclk_wait(input int n);
        repeat (n) @(posedge clk);
        #(phase);
    endtask

    task automatic shift_bits(input logic [7:0] b, input int nbits, output logic [7:0] m);
        m = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            spi_mosi = b[7-k];
            sclk_wait(4);
            spi_sclk = 1'b1;
            m = {m[6:0], spi_miso};
            sclk_wait(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input int nbytes, input int tail);
        logic [7:0] m;
        spi_cs_n = 1'b0;
        sclk_wait(6);
        for (int i = 0; i < nbytes; i++) begin
            shift_bits(mbytes[i], 8, m);
            miso_bytes.push_back(m);
        end
        if (tail > 0) shift_bits(mbytes[nbytes], tail, m);
        sclk_wait(6);
        spi_cs_n = 1'b1;
        sclk_wait(14);
    endtask

    // Compare everything observed since the last call with the model, then clear both
    task automatic verify(input string tag);
        check_eq($sformatf("%s_rx_count", tag), obs_rx.size(), exp_rx.size());
        for (int i = 0; i < obs_rx.size() && i < exp_rx.size(); i++)
            check_eq($sformatf("%s_rx%0d", tag, i), obs_rx[i], exp_rx[i]);
        check_eq($sformatf("%s_width_count", tag), obs_w.size(), obs_rx.size());
        for (int i = 0; i < obs_w.size(); i++)
            check_eq($sformatf("%s_width%0d", tag, i), obs_w[i], VALID_HOLD);
        check_eq($sformatf("%s_miso_count", tag), miso_bytes.size(), exp_miso.size());
        for (int i = 0; i < miso_bytes.size() && i < exp_miso.size(); i++)
            check_eq($sformatf("%s_miso%0d", tag, i), miso_bytes[i], exp_miso[i]);
        check_eq($sformatf("%s_acks", tag), ack_cnt, exp_ack);
        check_eq($sformatf("%s_aborts", tag), abort_cnt, exp_abort);
        check_eq($sformatf("%s_data_stable", tag), unstable_cnt, 0);
        check_eq($sformatf("%s_oe_after", tag), spi_miso_oe, 1'b0);
        check_eq($sformatf("%s_active_after", tag), frame_active, 1'b0);
        obs_rx.delete(); obs_w.delete(); miso_bytes.delete();
        exp_rx.delete(); exp_miso.delete();
        ack_cnt = 0; abort_cnt = 0; unstable_cnt = 0; exp_ack = 0; exp_abort = 0;
    endtask

    initial begin
        logic [7:0] m;
        int nb, tl;

        // Reset state
        rst = 1'b1;
        #2 rst = 1'b0;
        #3;
        check_eq("reset_outputs",
                 {spi_miso, spi_miso_oe, tx_load_ack, spi_rx_data, spi_rx_valid,
                  frame_active, rx_abort, byte_cnt}, 22'h0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        sclk_wait(10);

        // Single byte 0xF8
        mbytes[0] = 8'hF8;
        tx_data = 8'h00;
        exp_rx = '{8'hF8}; exp_miso = '{8'h00}; exp_ack = 2;
        send_frame(1, 0);
        verify("single");
        check_eq("single_byte_cnt", byte_cnt, 8'd1);

        // Three bytes in one frame; byte_cnt held after cs_n rises
        mbytes[0] = 8'hF8; mbytes[1] = 8'h12; mbytes[2] = 8'h34;
        exp_rx = '{8'hF8, 8'h12, 8'h34}; exp_miso = '{8'h00, 8'h00, 8'h00}; exp_ack = 4;
        send_frame(3, 0);
        verify("triple");
        check_eq("triple_byte_cnt", byte_cnt, 8'd3);

        // MISO: 0xA5 at frame start, 0x3C after the first load ack.
        // The fall after each byte reloads tx_data, so a 2-byte frame yields 3 acks.
        tx_data = 8'hA5;
        mbytes[0] = 8'h81; mbytes[1] = 8'h7E;
        exp_rx = '{8'h81, 8'h7E}; exp_miso = '{8'hA5, 8'h3C}; exp_ack = 3;
        check_eq("miso_oe_before", spi_miso_oe, 1'b0);
        fork
            send_frame(2, 0);
            begin
                int i;
                for (i = 0; i < 200 && tx_load_ack !== 1'b1; i++) @(negedge clk);
                check_eq("first_ack_seen", (i < 200), 1'b1);
                tx_data = 8'h3C;
            end
        join
        verify("miso");

        // Good byte then a frame aborted after 5 bits
        tx_data = 8'h00;
        mbytes[0] = 8'h55;
        send_frame(1, 0);
        mbytes[0] = 8'hC3;
        send_frame(0, 5);
        exp_rx = '{8'h55}; exp_miso = '{8'h00}; exp_ack = 3; exp_abort = 1;
        verify("abort");
        check_eq("abort_rx_data", spi_rx_data, 8'h55);
        check_eq("abort_byte_cnt", byte_cnt, 8'd0);

        // Reset mid-byte with cs_n held low: the running frame must not be joined
        spi_cs_n = 1'b0;
        sclk_wait(6);
        shift_bits(8'hE7, 4, m);
        rst = 1'b0;
        #3;
        check_eq("midreset_outputs",
                 {spi_miso, spi_miso_oe, tx_load_ack, spi_rx_data, spi_rx_valid,
                  frame_active, rx_abort, byte_cnt}, 22'h0);
        ack_cnt = 0; abort_cnt = 0; oe_cnt = 0;
        sclk_wait(2);
        rst = 1'b1;
        shift_bits(8'hE7, 4, m);
        shift_bits(8'h99, 8, m);
        sclk_wait(12);
        check_eq("midreset_no_valid", obs_rx.size(), 0);
        check_eq("midreset_oe", oe_cnt, 0);
        check_eq("midreset_byte_cnt", byte_cnt, 8'd0);
        verify("midreset");
        spi_cs_n = 1'b1;
        sclk_wait(12);
        tx_data = 8'h6D;
        mbytes[0] = 8'hFA;
        exp_rx = '{8'hFA}; exp_miso = '{8'h6D}; exp_ack = 2;
        send_frame(1, 0);
        verify("postreset");
        check_eq("postreset_rx_data", spi_rx_data, 8'hFA);

        // SCLK activity while deselected is ignored
        oe_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            spi_mosi = 1'($urandom);
            sclk_wait(4);
            spi_sclk = ~spi_sclk;
        end
        sclk_wait(12);
        verify("idle_sclk");
        check_eq("idle_byte_cnt", byte_cnt, 8'd1);
        check_eq("idle_oe", oe_cnt, 0);

        // Randomized frames at varying sampling phase, some aborted mid-byte
        for (int f = 0; f < 8; f++) begin
            phase   = $urandom_range(1, 9);
            nb      = $urandom_range(1, 4);
            tl      = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
            tx_data = 8'($urandom);
            for (int i = 0; i < 5; i++) mbytes[i] = 8'($urandom);
            for (int i = 0; i < nb; i++) begin
                exp_rx.push_back(mbytes[i]);
                exp_miso.push_back(tx_data);
            end
            exp_ack   = nb + 1;
            exp_abort = (tl > 0) ? 1 : 0;
            sclk_wait($urandom_range(2, 20));
            send_frame(nb, tl);
            verify($sformatf("rand%0d", f));
            check_eq($sformatf("rand%0d_byte_cnt", f), byte_cnt, 32'(nb));
            check_eq($sformatf("rand%0d_rx_data", f), spi_rx_data, mbytes[nb-1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
